// File: rtl/mul_signed_arbiter.sv
// mul_signed_arbiter
//   Shares one signed W x W multiplier among NREQ requesters using
//   round-robin arbitration. The winner's operands are latched when the
//   grant is issued. The full 2*W-bit product is registered one cycle later.
//   A one-cycle done pulse then goes back to the winner.
//
// Ports
//   clk       in   rising-edge clock
//   clrn      in   asynchronous active-low clear
//   req       in   [NREQ]    request level per requester
//   a_bus     in   [NREQ*W]  packed multiplicands, slice i = a_bus[i*W +: W]
//   b_bus     in   [NREQ*W]  packed multipliers,   slice i = b_bus[i*W +: W]
//   gnt       out  [NREQ]    registered one-hot grant, high in MUL and DONE
//   done      out  [NREQ]    one-hot, one-cycle pulse in DONE; z is valid then
//   z         out  [2*W]     signed product, held until the next DONE
//   busy      out            high in MUL and DONE
//   state_dbg out  [2]       current FSM state (IDLE=0, MUL=1, DONE=2)
//
// Handshake: a requester holds req high with stable operands until it sees
// its gnt bit. Operands are sampled only at that grant edge. Its done bit
// pulses for exactly one cycle, and z is valid in that same cycle. req is
// ignored outside IDLE.
module mul_signed_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    z,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  z_q, z_d;

  // Round-robin pick: the search starts at ptr_q and wraps modulo NREQ.
  logic          found;
  logic [PW-1:0] sel;
  int            idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  // Sign-extend to the full product width so that no bits are lost.
  // For example, -128 * -128 = 0x4000.
  logic [2*W-1:0] a_ext, b_ext;
  assign a_ext = {{W{a_q[W-1]}}, a_q};
  assign b_ext = {{W{b_q[W-1]}}, b_q};

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_MUL;
          gnt_d   = ONE_HOT0 << sel;
          gidx_d  = sel;
          a_d     = a_bus[int'(sel)*W +: W];
          b_d     = b_bus[int'(sel)*W +: W];
        end
      end
      ST_MUL: begin
        z_d     = a_ext * b_ext;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = '0;
        // Advance past the winner so that it queues behind the other requesters.
        ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
    end
  end

  // done is decoded from state, so reset clears it immediately.
  assign done      = (state_q == ST_DONE) ? gnt_q : '0;
  assign gnt       = gnt_q;
  assign z         = z_q;
  assign busy      = (state_q == ST_MUL) || (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_signed_arbiter.sv
module tb_mul_signed_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int EW   = NREQ + 2*W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              clrn;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_bus, b_bus;
  logic [NREQ-1:0]   gnt, done;
  logic [2*W-1:0]    z;
  logic              busy;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  mul_signed_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .clrn(clrn), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .done(done), .z(z), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every done pulse must match the oldest expected {done, z} entry.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (done !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("done_id", 32'(done), 32'(e[EW-1:2*W]));
        check("z", 32'(z), 32'(e[2*W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return p;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One isolated op on requester i: req is dropped right after the grant.
  task automatic single_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] zexp, input string tag);
    set_ops(i, a, b);
    req = oh(i);
    exp_q.push_back({oh(i), zexp});
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(oh(i)));
    req = '0;
    tick();
    tick();
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] z;
  } vec_t;

  vec_t vecs[6];
  logic [W-1:0] ra[NREQ];
  logic [W-1:0] rb[NREQ];

  initial begin
    vecs[0] = '{8'h7f, 8'h7f, 16'h3f01};
    vecs[1] = '{8'h81, 8'h81, 16'h3f01};
    vecs[2] = '{8'h7e, 8'h81, 16'hc17e};
    vecs[3] = '{8'h82, 8'h7d, 16'hc27a};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'h00, 8'h05, 16'h0000};

    clrn = 1'b0; req = '0; a_bus = '0; b_bus = '0;
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_z", 32'(z), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    tick();
    clrn = 1'b1;
    tick();

    // Test 1: -1 * -1 on requester 0, with the timing checked step by step.
    set_ops(0, 8'hff, 8'hff);
    req = 4'b0001;
    exp_q.push_back({4'b0001, 16'h0001});
    check("t1_pre_gnt", 32'(gnt), 32'h0);
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_done_mul", 32'(done), 32'h0);
    check("t1_state_mul", 32'(state_dbg), 32'h1);
    req = '0;
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_z", 32'(z), 32'h0001);
    tick();
    check("t1_done_off", 32'(done), 32'h0);
    check("t1_gnt_off", 32'(gnt), 32'h0);
    check("t1_busy_off", 32'(busy), 32'h0);

    // Test 2: directed signed corner products on requester 2.
    foreach (vecs[k]) single_op(2, vecs[k].a, vecs[k].b, vecs[k].z, "t2");

    // Test 3: every requester held high, with ptr starting at 0 after a reset.
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 8'($urandom_range(0, 255));
      rb[i] = 8'($urandom_range(0, 255));
      set_ops(i, ra[i], rb[i]);
    end
    for (int n = 0; n < 5; n++)
      exp_q.push_back({oh(n % NREQ), ref_mul(ra[n % NREQ], rb[n % NREQ])});
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t3_gnt", 32'(gnt), 32'(oh(n % NREQ)));
      tick();
      check("t3_done", 32'(done), 32'(oh(n % NREQ)));
      tick();
      check("t3_gap", 32'(done), 32'h0);
    end
    req = '0;
    tick();

    // Test 4: an operand changed after the grant must be ignored.
    set_ops(1, 8'h03, 8'h05);
    req = 4'b0010;
    exp_q.push_back({4'b0010, 16'h000f});
    tick();
    check("t4_gnt", 32'(gnt), 32'h2);
    req = '0;
    b_bus[1*W +: W] = 8'h7f;
    tick();
    tick();

    // Test 5: reset during MUL drops the operation at once, and no done follows.
    set_ops(0, 8'h11, 8'h22);
    req = 4'b0001;
    tick();
    check("t5_state_mul", 32'(state_dbg), 32'h1);
    clrn = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    check("t5_z", 32'(z), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    req = '0;
    tick();
    clrn = 1'b1;
    repeat (3) tick();
    check("t5_quiet", 32'(busy), 32'h0);
    single_op(3, 8'hf0, 8'h10, 16'hff00, "t5_r3");

    // Test 6: req dropped after the grant still completes the op, then the FSM idles.
    single_op(0, 8'h80, 8'h7f, 16'hc080, "t6");
    tick();
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_state", 32'(state_dbg), 32'h0);
    check("t6_gnt", 32'(gnt), 32'h0);

    repeat (2) tick();
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
